recip_arbiter: RTL and testbench

- Round-robin arbiter and sequencer sharing one iterative fixed-point reciprocal engine among N requesters.
- Accepts one operand at a time, pulses the engine start and holds its operand stable until done, then routes result and invalid flag back to the requester.
- Adds a watchdog timeout so a hung engine cannot stall requesters forever.
- Sits between per-channel consumers (e.g. normalisation stages) and the single reciprocal engine.

---
 rtl/recip_arb_pkg.sv | 6 +
 rtl/rr_pick.sv | 25 ++
 rtl/recip_arbiter.sv | 94 +++++++++
 tb/tb_recip_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/recip_arb_pkg.sv
// recip_arb_pkg: sequencer state encoding and default watchdog limit
// for the shared reciprocal engine arbiter.
package recip_arb_pkg;
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_FLUSH} st_t;
   localparam int TIMEOUT_DEF = 32;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; search starts at ptr and wraps,
// returning a one-hot grant, its index and whether anything was requesting.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);
   localparam int IW = $clog2(N);
   logic [N-1:0] rot;
   logic [IW:0]  sum;
   logic [IW-1:0] off;
   always_comb begin
      rot = N'({req, req} >> ptr);
      off = '0;
      any = |rot;
      for (int k = N - 1; k >= 0; k--) if (rot[k]) off = IW'(k);
      sum = {1'b0, ptr} + {1'b0, off};
      idx = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];
      gnt = any ? (N'(1) << idx) : '0;
   end
endmodule

// File: rtl/recip_arbiter.sv
// recip_arbiter: round-robin sequencer sharing one iterative reciprocal engine
// among N requesters, with a watchdog that aborts and flushes a hung engine.
module recip_arbiter
   import recip_arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int W       = 32,
   parameter int F       = 16,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req_valid,
   output logic [N-1:0]   req_ready,
   input  logic [N*W-1:0] req_x,
   output logic [N-1:0]   rsp_valid,
   input  logic [N-1:0]   rsp_ready,
   output logic [W-1:0]   rsp_data,
   output logic           rsp_invalid,
   output logic           rsp_timeout,
   output logic           eng_start,
   output logic [W-1:0]   eng_x,
   input  logic           eng_done,
   input  logic [W-1:0]   eng_result,
   input  logic           eng_invalid
);
   localparam int IW = $clog2(N);
   localparam int TW = $clog2(TIMEOUT) + 1;
   if (N < 2 || N > 8 || F >= W || TIMEOUT < 2) begin : g_bad_param
      $error("recip_arbiter: parameter out of range");
   end
   st_t state, state_nx;
   logic [IW-1:0] ptr, id, g_idx;
   logic [N-1:0]  gnt;
   logic          g_any, flush, wait_to, flush_to, rsp_hs;
   logic [TW-1:0] tmr;
   logic [W-1:0]  sel_x;
   rr_pick #(.N(N)) u_pick (
      .req (req_valid),
      .ptr (ptr),
      .gnt (gnt),
      .idx (g_idx),
      .any (g_any)
   );
   assign req_ready = (state == S_IDLE && rst_n) ? gnt : '0;
   assign rsp_valid = (state == S_RESP) ? (N'(1) << id) : '0;
   assign eng_start = state == S_ISSUE;
   // timer is cleared on entry, so WAIT aborts as its count steps onto TIMEOUT-1
   assign wait_to   = tmr == TW'(TIMEOUT - 2);
   assign flush_to  = tmr == TW'(TIMEOUT - 1);
   assign rsp_hs    = |(rsp_valid & rsp_ready);
   always_comb begin
      sel_x = '0;
      for (int i = 0; i < N; i++) if (g_idx == IW'(i)) sel_x = req_x[i*W +: W];
   end
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  state_nx = g_any ? S_ISSUE : S_IDLE;
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT:  state_nx = (eng_done || wait_to) ? S_RESP : S_WAIT;
         S_RESP:  state_nx = rsp_hs ? (flush ? S_FLUSH : S_IDLE) : S_RESP;
         S_FLUSH: state_nx = (eng_done || flush_to) ? S_IDLE : S_FLUSH;
         default: state_nx = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         ptr         <= '0;
         id          <= '0;
         flush       <= 1'b0;
         tmr         <= '0;
         eng_x       <= '0;
         rsp_data    <= '0;
         rsp_invalid <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         state <= state_nx;
         tmr   <= (state == S_WAIT || state == S_FLUSH) ? (&tmr ? tmr : tmr + 1'b1) : '0;
         if (state == S_IDLE && g_any) begin
            eng_x <= sel_x;
            id    <= g_idx;
            ptr   <= (g_idx == IW'(N - 1)) ? '0 : g_idx + 1'b1;
         end
         if (state == S_WAIT && (eng_done || wait_to)) begin
            rsp_data    <= eng_done ? eng_result : '0;
            rsp_invalid <= eng_done && eng_invalid;
            rsp_timeout <= !eng_done;
            flush       <= !eng_done;
         end
      end
   end
endmodule

// File: tb/tb_recip_arbiter.sv
// tb_recip_arbiter: directed scoreboard bench; stimulus pushes expected
// responses, a negedge monitor pops and compares on every response handshake.
module tb_recip_arbiter;
   localparam int N = 4, W = 32, F = 16, TIMEOUT = 32;
   logic clk = 0, rst_n = 0;
   logic [N-1:0] req_valid = '0, rsp_ready = '1;
   logic [N*W-1:0] req_x = '0;
   logic [N-1:0] req_ready, rsp_valid;
   logic [W-1:0] rsp_data, eng_x, eng_result = '0;
   logic rsp_invalid, rsp_timeout, eng_start, eng_done = 0, eng_invalid = 0;
   logic hang = 0;
   int tests = 0, fails = 0, cyc = 0, late_req = 0;
   typedef struct {int id; logic [W-1:0] data; logic inv; logic to;} exp_t;
   exp_t sb[$];
   logic [W-1:0] rr_exp [N] = '{32'h0001_0000, 32'h0000_8000, 32'h0000_5555, 32'h0000_4000};

   recip_arbiter #(.N(N), .W(W), .F(F), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_invalid(rsp_invalid), .rsp_timeout(rsp_timeout),
      .eng_start(eng_start), .eng_x(eng_x), .eng_done(eng_done),
      .eng_result(eng_result), .eng_invalid(eng_invalid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int id, input logic [W-1:0] d, input logic inv, input logic to);
      exp_t e;
      e.id = id; e.data = d; e.inv = inv; e.to = to;
      sb.push_back(e);
   endtask

   // waits for any grant, checks it is requester i, completes the handshake
   task automatic grant(input int i, input logic [N-1:0] clr, output int sc);
      int n = 0;
      #1;
      while (req_ready == '0 && n < 200) begin @(posedge clk); #1; n++; end
      check($sformatf("grant_%0d", i), req_ready, N'(1) << i);
      @(posedge clk); #1;
      req_valid &= ~clr;
      sc = cyc;
      check("eng_start_lat", eng_start, 1);
   endtask

   task automatic send(input int i, input logic [W-1:0] x, output int sc);
      req_x[i*W +: W] = x;
      req_valid[i] = 1'b1;
      grant(i, N'(1) << i, sc);
   endtask

   task automatic wait_rsp(output int rc);
      int n = 0;
      while (rsp_valid == '0 && n < 200) begin @(posedge clk); #1; n++; end
      rc = cyc;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
      check("drain", sb.size(), 0);
   endtask

   // engine model: two-cycle latency, Q16 reciprocal, optional hang and late-done injection
   initial begin
      int cnt = 0, late_ack = 0;
      logic busy = 0;
      logic [W-1:0] x = '0;
      forever begin
         @(posedge clk); #1;
         eng_done = 0; eng_invalid = 0; eng_result = '0;
         if (!rst_n) busy = 0;
         else if (late_req != late_ack) begin
            late_ack = late_req;
            eng_done = 1; eng_invalid = 1; eng_result = 32'hDEAD_BEEF;
         end else if (busy && cnt > 0) cnt--;
         else if (busy) begin
            busy = 0;
            eng_done = 1;
            check("eng_x_held", eng_x, x);
            eng_invalid = ($signed(x) <= 0);
            eng_result = eng_invalid ? '0 : W'((64'sd1 <<< (2 * F)) / longint'($signed(x)));
         end else if (eng_start && !hang) begin
            busy = 1; x = eng_x; cnt = 1;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (rsp_valid & rsp_ready) != '0) begin
         if (sb.size() == 0) check("rsp_unexpected", rsp_valid, 0);
         else begin
            e = sb.pop_front();
            check("rsp_id", rsp_valid, N'(1) << e.id);
            check("rsp_data", rsp_data, e.data);
            check("rsp_invalid", rsp_invalid, e.inv);
            check("rsp_timeout", rsp_timeout, e.to);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int sc, rc, sc2;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) req_x[i*W +: W] = W'(i + 1) << F;
      req_valid = '1;
      #1;
      check("reset_ctl", {req_ready, rsp_valid, rsp_invalid, rsp_timeout, eng_start}, 0);
      check("reset_data", {rsp_data, eng_x}, 0);
      // fairness: all requesting from reset, expect 0,1,2,3,0
      for (int k = 0; k <= N; k++) push(k % N, rr_exp[k % N], 0, 0);
      rst_n = 1;
      for (int k = 0; k <= N; k++) grant(k % N, (k == N) ? '1 : '0, sc);
      drain();
      // basic 2.0 -> 0.5 and latency
      push(0, 32'h0000_8000, 0, 0);
      send(0, 32'h0002_0000, sc);
      wait_rsp(rc);
      check("rsp_lat", rc - sc, 3);
      drain();
      // non-positive operands
      push(2, 0, 1, 0);
      send(2, 32'h0000_0000, sc);
      drain();
      push(2, 0, 1, 0);
      send(2, 32'hFFFB_0000, sc);
      drain();
      // response backpressure with another requester pending
      rsp_ready[1] = 0;
      push(1, 32'h0000_2000, 0, 0);
      send(1, 32'h0008_0000, sc);
      req_x[0 +: W] = 32'h0001_0000;
      req_valid[0] = 1;
      push(0, 32'h0001_0000, 0, 0);
      wait_rsp(rc);
      repeat (5) begin
         @(posedge clk); #1;
         check("bp_valid", rsp_valid, 4'b0010);
         check("bp_data", rsp_data, 32'h0000_2000);
         check("bp_stall", {req_ready, eng_start}, 0);
      end
      rsp_ready[1] = 1;
      grant(0, 4'b0001, sc);
      drain();
      // hung engine: timeout latency, then flush runs its full length
      hang = 1;
      push(0, 0, 0, 1);
      send(0, 32'h0003_0000, sc);
      wait_rsp(rc);
      check("timeout_lat", rc - sc, TIMEOUT);
      hang = 0;
      req_x[1*W +: W] = 32'h0002_0000;
      req_valid[1] = 1;
      push(1, 32'h0000_8000, 0, 0);
      grant(1, 4'b0010, sc2);
      check("flush_exit", sc2 - rc, TIMEOUT + 2);
      drain();
      // hung engine, then a late done ends the flush early and is discarded
      hang = 1;
      push(0, 0, 0, 1);
      send(0, 32'h0005_0000, sc);
      wait_rsp(rc);
      req_x[0 +: W] = 32'h0004_0000;
      req_valid[0] = 1;
      push(0, 32'h0000_4000, 0, 0);
      repeat (5) begin
         @(posedge clk); #1;
         check("flush_hold", {req_ready, eng_start}, 0);
      end
      hang = 0;
      late_req++;
      grant(0, 4'b0001, sc);
      check("late_done_exit", (sc - rc) < TIMEOUT, 1);
      drain();
      // asynchronous reset mid-WAIT, then pointer restarts at 0
      hang = 1;
      send(2, 32'h0007_0000, sc);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      check("rst_mid_ctl", {req_ready, rsp_valid, rsp_invalid, rsp_timeout, eng_start}, 0);
      check("rst_mid_data", {rsp_data, eng_x}, 0);
      @(posedge clk); #1;
      req_x[1*W +: W] = 32'h0002_0000;
      req_x[3*W +: W] = 32'h0004_0000;
      req_valid = 4'b1010;
      #1;
      check("rst_hold_ready", req_ready, 0);
      hang = 0;
      push(1, 32'h0000_8000, 0, 0);
      push(3, 32'h0000_4000, 0, 0);
      rst_n = 1;
      grant(1, 4'b0010, sc);
      grant(3, 4'b1000, sc);
      drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
